sm4_round_sequencer: RTL and testbench

SM4_ROUND_SEQUENCER -- requirements
Module: sm4_round_sequencer

---
 rtl/sm4_encryptor.sv | 7 +
 rtl/sm4_round_sequencer.sv | 152 +++++++++++++++
 tb/tb_sm4_round_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sm4_encryptor.sv
// sm4_encryptor: shared width constants for the SM4 datapath.
//   group_size_p : block / key width in bits
//   word_width_p : width of one SM4 word (one round key, one state word)
package sm4_encryptor;
    localparam int group_size_p = 128;
    localparam int word_width_p = 32;
endpackage

// File: rtl/sm4_round_sequencer.sv
// sm4_round_sequencer: drives a shared SM4 turn_transform through the
// 32-round key expansion and the 32-round encrypt/decrypt iteration, and
// keeps the expanded round keys for later blocks.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   key_v_i/key_i           master key in; accepted when key_ready_o=1
//   key_ready_o             high only while idle
//   data_v_i/data_i         block in; accepted when ready_o=1
//   decrypt_i               sampled with the block; 1 selects decryption
//   ready_o                 idle, keys expanded and no key load pending
//   v_o/data_o/yumi_i       result out; held until yumi_i
//   keys_valid_o            round-key store holds a completed expansion
//   tt_i_o/tt_is_key_o      turn_transform input word group and mode
//   tt_rkey_o/tt_o_i        turn_transform round key / result word
//
// state   | meaning
// IDLE    | waiting for a key load or a block
// KEY_EXP | 32 key-expansion rounds, writing rk[rnd]
// CRYPT   | 32 cipher rounds using the stored round keys
// DONE    | result presented on data_o until yumi_i
module sm4_round_sequencer
    import sm4_encryptor::*;
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    key_v_i,
    input  logic [group_size_p-1:0] key_i,
    output logic                    key_ready_o,
    input  logic                    data_v_i,
    input  logic [group_size_p-1:0] data_i,
    input  logic                    decrypt_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [group_size_p-1:0] data_o,
    input  logic                    yumi_i,
    output logic                    keys_valid_o,
    output logic [group_size_p-1:0] tt_i_o,
    output logic                    tt_is_key_o,
    output logic [word_width_p-1:0] tt_rkey_o,
    input  logic [word_width_p-1:0] tt_o_i
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] KEY_EXP = 2'd1;
    localparam logic [1:0] CRYPT   = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [word_width_p-1:0] FK0 = 32'hA3B1BAC6;
    localparam logic [word_width_p-1:0] FK1 = 32'h56AA3350;
    localparam logic [word_width_p-1:0] FK2 = 32'h677D9197;
    localparam logic [word_width_p-1:0] FK3 = 32'hB27022DC;

    logic [1:0]              state_r;
    logic [4:0]              rnd_r;
    logic [word_width_p-1:0] s0_r, s1_r, s2_r, s3_r;
    logic                    keys_valid_r;
    logic                    dec_r;
    logic [word_width_p-1:0] rk_r [32];

    logic                    last_rnd;
    logic [7:0]              ck_b0;
    logic [word_width_p-1:0] ck;
    logic [4:0]              rk_idx;

    assign last_rnd = (rnd_r == 5'd31);

    // CK[i] byte j = (4i+j)*7 mod 256; bytes 1..3 are byte 0 plus 7, 14, 21.
    assign ck_b0 = {1'b0, rnd_r, 2'b00} * 8'd7;
    assign ck    = {ck_b0, ck_b0 + 8'd7, ck_b0 + 8'd14, ck_b0 + 8'd21};

    // Decryption walks the same schedule backwards: 31-rnd == ~rnd in 5 bits.
    assign rk_idx = dec_r ? ~rnd_r : rnd_r;

    assign key_ready_o  = (state_r == IDLE);
    assign ready_o      = (state_r == IDLE) & keys_valid_r & ~key_v_i;
    assign v_o          = (state_r == DONE);
    assign data_o       = {s3_r, s2_r, s1_r, s0_r};
    assign tt_i_o       = {s3_r, s2_r, s1_r, s0_r};
    assign tt_is_key_o  = (state_r == KEY_EXP);
    assign keys_valid_o = keys_valid_r;

    always_comb begin
        tt_rkey_o = '0;
        case (state_r)
            KEY_EXP: tt_rkey_o = ck;
            CRYPT:   tt_rkey_o = rk_r[rk_idx];
            default: tt_rkey_o = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= IDLE;
            rnd_r        <= '0;
            s0_r         <= '0;
            s1_r         <= '0;
            s2_r         <= '0;
            s3_r         <= '0;
            keys_valid_r <= 1'b0;
            dec_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (key_v_i) begin
                        s0_r         <= key_i[127:96] ^ FK0;
                        s1_r         <= key_i[95:64]  ^ FK1;
                        s2_r         <= key_i[63:32]  ^ FK2;
                        s3_r         <= key_i[31:0]   ^ FK3;
                        keys_valid_r <= 1'b0;
                        rnd_r        <= '0;
                        state_r      <= KEY_EXP;
                    end else if (data_v_i && keys_valid_r) begin
                        s0_r    <= data_i[127:96];
                        s1_r    <= data_i[95:64];
                        s2_r    <= data_i[63:32];
                        s3_r    <= data_i[31:0];
                        dec_r   <= decrypt_i;
                        rnd_r   <= '0;
                        state_r <= CRYPT;
                    end
                end
                KEY_EXP, CRYPT: begin
                    s0_r  <= s1_r;
                    s1_r  <= s2_r;
                    s2_r  <= s3_r;
                    s3_r  <= tt_o_i;
                    // 5-bit increment returns rnd to 0 exactly on the exit round.
                    rnd_r <= rnd_r + 5'd1;
                    if (last_rnd) begin
                        if (state_r == KEY_EXP) begin
                            keys_valid_r <= 1'b1;
                            state_r      <= IDLE;
                        end else begin
                            state_r <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (yumi_i) state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Round-key store is deliberately not reset; keys_valid_r guards its use.
    always_ff @(posedge clk_i) begin
        if (!reset_i && state_r == KEY_EXP) rk_r[rnd_r] <= tt_o_i;
    end

endmodule

// File: tb/tb_sm4_round_sequencer.sv
// tb_sm4_round_sequencer: directed bench for sm4_round_sequencer. A
// behavioural SM4 turn_transform answers on tt_o_i; expected results are the
// published SM4 example vectors.
module tb_sm4_round_sequencer;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         key_v_i;
    logic [127:0] key_i;
    logic         key_ready_o;
    logic         data_v_i;
    logic [127:0] data_i;
    logic         decrypt_i;
    logic         ready_o;
    logic         v_o;
    logic [127:0] data_o;
    logic         yumi_i;
    logic         keys_valid_o;
    logic [127:0] tt_i_o;
    logic         tt_is_key_o;
    logic [31:0]  tt_rkey_o;
    logic [31:0]  tt_o_i;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] CT  = 128'h681EDF34D206965E86B3E94F536E4246;

    sm4_round_sequencer dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .key_v_i      (key_v_i),
        .key_i        (key_i),
        .key_ready_o  (key_ready_o),
        .data_v_i     (data_v_i),
        .data_i       (data_i),
        .decrypt_i    (decrypt_i),
        .ready_o      (ready_o),
        .v_o          (v_o),
        .data_o       (data_o),
        .yumi_i       (yumi_i),
        .keys_valid_o (keys_valid_o),
        .tt_i_o       (tt_i_o),
        .tt_is_key_o  (tt_is_key_o),
        .tt_rkey_o    (tt_rkey_o),
        .tt_o_i       (tt_o_i)
    );

    always #5 clk_i = ~clk_i;

    logic [0:255][7:0] sbox_tab = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // SM4 round: o = X0 ^ L(tau(X1 ^ X2 ^ X3 ^ rk)); L' for key expansion.
    function automatic logic [31:0] tt_model(input logic [127:0] i,
                                             input logic is_key,
                                             input logic [31:0] rk);
        logic [31:0] x, b, l;
        x = i[63:32] ^ i[95:64] ^ i[127:96] ^ rk;
        b = {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
        if (is_key) l = b ^ rol(b, 13) ^ rol(b, 23);
        else        l = b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
        return i[31:0] ^ l;
    endfunction

    always_comb tt_o_i = tt_model(tt_i_o, tt_is_key_o, tt_rkey_o);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Called right after the key-transfer edge.
    task automatic key_expand();
        chk("kexp_is_key", tt_is_key_o, 1);
        chk("kexp_ck0", tt_rkey_o, 32'h00070E15);
        chk("kexp_rk0", tt_o_i, 32'hF12186F9);
        chk("kexp_no_key_ready", key_ready_o, 0);
        repeat (31) tick();
        chk("kexp_rk31", tt_o_i, 32'h9124A012);
        chk("kexp_ck31", tt_rkey_o, 32'h646B7279);
        chk("kexp_kv_early", keys_valid_o, 0);
        tick();
        chk("kexp_kv_latency", keys_valid_o, 1);
        chk("kexp_ready_after", ready_o, 1);
        chk("kexp_is_key_idle", tt_is_key_o, 0);
    endtask

    task automatic run_block(input logic [127:0] din, input logic dec,
                             input logic [31:0] exp_rk_first,
                             input logic [127:0] exp_out);
        int n;
        data_v_i  = 1'b1;
        data_i    = din;
        decrypt_i = dec;
        #1;
        chk("blk_ready", ready_o, 1);
        tick();
        data_v_i  = 1'b0;
        data_i    = '0;
        decrypt_i = 1'b0;
        chk("blk_first_rkey", tt_rkey_o, exp_rk_first);
        chk("blk_is_key", tt_is_key_o, 0);
        n = 0;
        while (!v_o && n < 40) begin
            tick();
            n++;
        end
        chk("blk_latency", n, 32);
        chk("blk_data_o", data_o, exp_out);
        chk("blk_rkey_done", tt_rkey_o, 0);
    endtask

    initial begin
        bit saw_v;
        reset_i   = 1'b1;
        key_v_i   = 1'b0;
        key_i     = '0;
        data_v_i  = 1'b0;
        data_i    = '0;
        decrypt_i = 1'b0;
        yumi_i    = 1'b0;
        repeat (2) tick();
        reset_i = 1'b0;
        #1;
        chk("rst_key_ready", key_ready_o, 1);
        chk("rst_ready", ready_o, 0);
        chk("rst_keys_valid", keys_valid_o, 0);
        chk("rst_v", v_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_is_key", tt_is_key_o, 0);
        chk("rst_rkey", tt_rkey_o, 0);

        // Block offered before any key load is refused.
        data_v_i = 1'b1;
        data_i   = KEY;
        #1;
        chk("nokey_ready", ready_o, 0);
        tick();
        data_v_i = 1'b0;
        chk("nokey_still_idle", key_ready_o, 1);
        chk("nokey_data_o", data_o, 0);

        // Key load and expansion.
        key_v_i = 1'b1;
        key_i   = KEY;
        #1;
        chk("key_ready_idle", key_ready_o, 1);
        tick();
        key_v_i = 1'b0;
        key_i   = '0;
        key_expand();

        // Encrypt the standard plaintext.
        run_block(KEY, 1'b0, 32'hF12186F9, CT);

        // Hold in DONE with competing requests; nothing may be accepted.
        key_v_i  = 1'b1;
        key_i    = CT;
        data_v_i = 1'b1;
        data_i   = CT;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("hold_v", v_o, 1);
            chk("hold_data_o", data_o, CT);
        end
        chk("hold_key_ready", key_ready_o, 0);
        chk("hold_ready", ready_o, 0);
        key_v_i  = 1'b0;
        data_v_i = 1'b0;
        yumi_i   = 1'b1;
        tick();
        yumi_i = 1'b0;
        chk("yumi_v_drop", v_o, 0);
        chk("yumi_idle", key_ready_o, 1);
        chk("yumi_keys_kept", keys_valid_o, 1);

        // Decrypt back with the retained round keys.
        run_block(CT, 1'b1, 32'h9124A012, KEY);
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;

        // Key and block together: key wins.
        key_v_i  = 1'b1;
        key_i    = KEY;
        data_v_i = 1'b1;
        data_i   = CT;
        #1;
        chk("both_ready", ready_o, 0);
        chk("both_key_ready", key_ready_o, 1);
        tick();
        key_v_i  = 1'b0;
        data_v_i = 1'b0;
        chk("both_kv_drop", keys_valid_o, 0);
        key_expand();

        // Reset in round 16 of an encryption.
        data_v_i  = 1'b1;
        data_i    = KEY;
        decrypt_i = 1'b0;
        tick();
        data_v_i = 1'b0;
        repeat (16) tick();
        chk("mid_no_v", v_o, 0);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("abort_idle", key_ready_o, 1);
        chk("abort_kv", keys_valid_o, 0);
        chk("abort_ready", ready_o, 0);
        chk("abort_v", v_o, 0);
        chk("abort_data_o", data_o, 0);
        saw_v = 1'b0;
        repeat (40) begin
            tick();
            if (v_o) saw_v = 1'b1;
        end
        chk("abort_never_v", saw_v, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
